// File: rtl/change_dispenser.sv
// change_dispenser
// Greedy change-making engine. A requested amount is paid out from N coin
// channels, largest denomination first, one coin or one channel advance per
// cycle, without ever taking more coins from a channel than it holds. On
// success the per-channel coin counts are published and the inventory is
// debited; on failure nothing is dispensed. Channels can be refilled at any
// time with saturating arithmetic.

`timescale 1ns/1ps

module change_dispenser #(
    parameter int               W        = 7,
    parameter int               N        = 3,
    parameter int               CW       = 4,
    parameter logic [N*W-1:0]   DENOM    = {7'd5, 7'd10, 7'd25},
    parameter int               INIT_INV = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [W-1:0]          amount,
    output logic                  ready,
    output logic                  done,
    output logic                  fail,
    output logic [N*CW-1:0]       counts,
    input  logic                  refill,
    input  logic [$clog2(N)-1:0]  refill_ch,
    input  logic [CW-1:0]         refill_qty,
    output logic [N*CW-1:0]       inventory
);

    localparam int            CHW      = $clog2(N);
    localparam logic [CW-1:0] INV_INIT = CW'(INIT_INV);
    localparam logic [CHW-1:0] LAST_CH = CHW'(N - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_FAIL   = 2'd3;

    logic [1:0]     state, state_nxt;
    logic [W-1:0]   rem, rem_nxt;
    logic [CHW-1:0] ch, ch_nxt;
    logic           load_counts;

    logic [CW-1:0]  work     [N];
    logic [CW-1:0]  work_nxt [N];
    logic [CW-1:0]  inv      [N];
    logic [CW-1:0]  inv_nxt  [N];
    logic [CW-1:0]  inv_base [N];
    logic [CW-1:0]  inv_add  [N];
    logic [CW:0]    inv_sum  [N];

    logic [W-1:0]   cur_denom;
    logic [CW-1:0]  cur_work;
    logic [CW-1:0]  cur_inv;
    logic           can_take;
    logic [W-1:0]   rem_after;

    // Pick out the denomination, working count and stock of the channel under consideration
    always_comb begin
        cur_denom = '0;
        cur_work  = '0;
        cur_inv   = '0;
        for (int i = 0; i < N; i++) begin
            if (ch == CHW'(i)) begin
                cur_denom = DENOM[i*W +: W];
                cur_work  = work[i];
                cur_inv   = inv[i];
            end
        end
    end

    // A coin may be taken only if it fits the remainder and the channel still has stock left
    assign can_take  = (rem >= cur_denom) && (cur_work < cur_inv);
    assign rem_after = rem - cur_denom;

    // Controller: capture a request in IDLE, then make one greedy decision per CALC cycle
    always_comb begin
        state_nxt   = state;
        rem_nxt     = rem;
        ch_nxt      = ch;
        load_counts = 1'b0;
        for (int i = 0; i < N; i++) begin
            work_nxt[i] = work[i];
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    rem_nxt   = amount;
                    ch_nxt    = '0;
                    state_nxt = S_CALC;
                    for (int i = 0; i < N; i++) begin
                        work_nxt[i] = '0;
                    end
                end
            end
            S_CALC: begin
                if (rem == '0) begin
                    state_nxt   = S_COMMIT;
                    load_counts = 1'b1;
                end else if (can_take) begin
                    rem_nxt = rem_after;
                    for (int i = 0; i < N; i++) begin
                        if (ch == CHW'(i)) begin
                            work_nxt[i] = work[i] + CW'(1);
                        end
                    end
                    if (rem_after == '0) begin
                        state_nxt   = S_COMMIT;
                        load_counts = 1'b1;
                    end
                end else if (ch < LAST_CH) begin
                    ch_nxt = ch + CHW'(1);
                end else begin
                    state_nxt = S_FAIL;
                end
            end
            S_COMMIT: state_nxt = S_IDLE;
            S_FAIL:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Inventory update: debit the dispensed coins in COMMIT, then add any refill with saturation
    always_comb begin
        for (int i = 0; i < N; i++) begin
            inv_base[i] = (state == S_COMMIT) ? (inv[i] - work[i]) : inv[i];
            inv_add[i]  = (refill && (refill_ch == CHW'(i))) ? refill_qty : '0;
            inv_sum[i]  = {1'b0, inv_base[i]} + {1'b0, inv_add[i]};
            inv_nxt[i]  = inv_sum[i][CW] ? '1 : inv_sum[i][CW-1:0];
        end
    end

    // Controller registers and published counts, which only change on entry to COMMIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            rem    <= '0;
            ch     <= '0;
            counts <= '0;
            for (int i = 0; i < N; i++) begin
                work[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            ch    <= ch_nxt;
            for (int i = 0; i < N; i++) begin
                work[i] <= work_nxt[i];
            end
            if (load_counts) begin
                for (int i = 0; i < N; i++) begin
                    counts[i*CW +: CW] <= work_nxt[i];
                end
            end
        end
    end

    // Coin stock per channel, restored to the initial fill on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                inv[i] <= INV_INIT;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                inv[i] <= inv_nxt[i];
            end
        end
    end

    // Flatten the inventory for the display/coin-output side
    always_comb begin
        inventory = '0;
        for (int i = 0; i < N; i++) begin
            inventory[i*CW +: CW] = inv[i];
        end
    end

    assign ready = (state == S_IDLE);
    assign done  = (state == S_COMMIT);
    assign fail  = (state == S_FAIL);

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
// Scoreboard bench for change_dispenser: every request pushes its predicted
// outcome (pass/fail, latency, coin counts) into a queue; the prediction is
// popped and compared when the DUT raises done or fail. A bench-side model
// of the coin stock tracks dispenses and refills.

`timescale 1ns/1ps

module tb_change_dispenser;

    localparam int W  = 7;
    localparam int N  = 3;
    localparam int CW = 4;
    localparam int MAXC = 15;

    logic            clk;
    logic            reset;
    logic            start;
    logic [W-1:0]    amount;
    logic            ready;
    logic            done;
    logic            fail;
    logic [N*CW-1:0] counts;
    logic            refill;
    logic [1:0]      refill_ch;
    logic [CW-1:0]   refill_qty;
    logic [N*CW-1:0] inventory;

    typedef struct {
        bit              is_fail;
        logic [N*CW-1:0] counts;
        int              lat;
    } exp_t;

    exp_t            sb[$];
    int              model_inv[N];
    logic [N*CW-1:0] model_counts;
    int              den[N] = '{25, 10, 5};
    int              checks;
    int              errors;

    change_dispenser #(
        .W(W), .N(N), .CW(CW),
        .DENOM({7'd5, 7'd10, 7'd25}),
        .INIT_INV(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .amount(amount),
        .ready(ready),
        .done(done),
        .fail(fail),
        .counts(counts),
        .refill(refill),
        .refill_ch(refill_ch),
        .refill_qty(refill_qty),
        .inventory(inventory)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a wait outside the bounded loops ever stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [N*CW-1:0] pack_inv();
        logic [N*CW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(model_inv[i]);
        return r;
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > MAXC) ? MAXC : a + b;
    endfunction

    // Per-channel greedy take = min(fit, stock); each coin is one cycle, each advance or the final refusal is one more
    function automatic exp_t predict(input int amt);
        exp_t e;
        int   rem, take, dec;
        rem       = amt;
        dec       = 0;
        e.counts  = '0;
        e.is_fail = 1'b0;
        if (rem == 0) begin
            e.lat = 2;
            return e;
        end
        for (int c = 0; c < N; c++) begin
            take = rem / den[c];
            if (take > model_inv[c]) take = model_inv[c];
            rem -= take * den[c];
            dec += take;
            e.counts[c*CW +: CW] = CW'(take);
            if (rem == 0) break;
            dec += 1;
        end
        e.is_fail = (rem != 0);
        e.lat     = dec + 1;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) model_inv[i] = 10;
        model_counts = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
        checks++;
        if (done !== 1'b0 || fail !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got done=%b fail=%b expected 0/0", done, fail); end
        checks++;
        if (counts !== '0) begin errors++; $display("[TB] FAIL reset_counts: got %h expected 000", counts); end
        checks++;
        if (inventory !== 12'haaa) begin errors++; $display("[TB] FAIL reset_inventory: got %h expected aaa", inventory); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Issue one request; optional start glitch during CALC and optional refill in the done/fail cycle
    task automatic run_request(input int amt, input bit glitch, input bit rf_en, input int rf_ch, input int rf_qty);
        exp_t e, got;
        int   cyc;
        bit   seen;
        e = predict(amt);
        sb.push_back(e);
        @(negedge clk);
        start  = 1'b1;
        amount = W'(amt);
        @(posedge clk);
        #1;
        start  = 1'b0;
        amount = '0;
        cyc    = 0;
        seen   = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (glitch && cyc == 2) begin
                start  = 1'b1;
                amount = 7'd5;
            end else begin
                start  = 1'b0;
            end
            if (done || fail) seen = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL req_timeout amt=%0d: got no done/fail expected one within %0d cycles", amt, e.lat);
            void'(sb.pop_front());
            return;
        end
        got = sb.pop_front();
        checks++;
        if (fail !== got.is_fail || done !== !got.is_fail) begin
            errors++;
            $display("[TB] FAIL outcome amt=%0d: got done=%b fail=%b expected fail=%b", amt, done, fail, got.is_fail);
        end
        checks++;
        if (cyc != got.lat) begin
            errors++;
            $display("[TB] FAIL latency amt=%0d: got %0d expected %0d", amt, cyc, got.lat);
        end
        if (!got.is_fail) begin
            model_counts = got.counts;
            for (int i = 0; i < N; i++) model_inv[i] -= int'(got.counts[i*CW +: CW]);
        end
        checks++;
        if (counts !== model_counts) begin
            errors++;
            $display("[TB] FAIL counts amt=%0d: got %h expected %h", amt, counts, model_counts);
        end
        if (rf_en) begin
            refill     = 1'b1;
            refill_ch  = 2'(rf_ch);
            refill_qty = CW'(rf_qty);
            if (rf_ch < N) model_inv[rf_ch] = sat_add(model_inv[rf_ch], rf_qty);
        end
        @(negedge clk);
        refill = 1'b0;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || fail !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_pulse amt=%0d: got ready=%b done=%b fail=%b expected 1/0/0", amt, ready, done, fail);
        end
        checks++;
        if (inventory !== pack_inv()) begin
            errors++;
            $display("[TB] FAIL inventory amt=%0d: got %h expected %h", amt, inventory, pack_inv());
        end
        checks++;
        if (counts !== model_counts) begin
            errors++;
            $display("[TB] FAIL counts_stable amt=%0d: got %h expected %h", amt, counts, model_counts);
        end
    endtask

    task automatic do_refill(input int rf_ch, input int rf_qty);
        @(negedge clk);
        refill     = 1'b1;
        refill_ch  = 2'(rf_ch);
        refill_qty = CW'(rf_qty);
        if (rf_ch < N) model_inv[rf_ch] = sat_add(model_inv[rf_ch], rf_qty);
        @(negedge clk);
        refill = 1'b0;
        checks++;
        if (inventory !== pack_inv()) begin
            errors++;
            $display("[TB] FAIL refill ch=%0d qty=%0d: got %h expected %h", rf_ch, rf_qty, inventory, pack_inv());
        end
    endtask

    task automatic test_greedy();
        run_request(65, 1'b0, 1'b0, 0, 0);
        checks++;
        if (counts !== 12'h112 || inventory !== 12'h998) begin
            errors++;
            $display("[TB] FAIL greedy_65: got counts=%h inv=%h expected 112/998", counts, inventory);
        end
    endtask

    task automatic test_zero();
        run_request(0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (counts !== 12'h000 || inventory !== 12'h998) begin
            errors++;
            $display("[TB] FAIL zero_amount: got counts=%h inv=%h expected 000/998", counts, inventory);
        end
    endtask

    task automatic test_indivisible();
        run_request(63, 1'b0, 1'b0, 0, 0);
        checks++;
        if (counts !== 12'h000 || inventory !== 12'h998) begin
            errors++;
            $display("[TB] FAIL indivisible_63: got counts=%h inv=%h expected 000/998", counts, inventory);
        end
    endtask

    task automatic test_exhaustion();
        test_reset();
        for (int k = 0; k < 5; k++) run_request(50, 1'b0, 1'b0, 0, 0);
        checks++;
        if (inventory[3:0] !== 4'd0) begin
            errors++;
            $display("[TB] FAIL exhaust_ch0: got %0d expected 0", inventory[3:0]);
        end
        run_request(50, 1'b0, 1'b0, 0, 0);
        checks++;
        if (counts !== 12'h050 || inventory[7:4] !== 4'd5) begin
            errors++;
            $display("[TB] FAIL exhaust_50: got counts=%h ch1=%0d expected 050/5", counts, inventory[7:4]);
        end
        run_request(75, 1'b0, 1'b0, 0, 0);
        checks++;
        if (counts !== 12'h550 || inventory !== 12'h500) begin
            errors++;
            $display("[TB] FAIL exhaust_75: got counts=%h inv=%h expected 550/500", counts, inventory);
        end
    endtask

    task automatic test_refill();
        test_reset();
        do_refill(2, 15);
        checks++;
        if (inventory !== 12'hfaa) begin
            errors++;
            $display("[TB] FAIL refill_sat: got %h expected faa", inventory);
        end
        do_refill(3, 5);
        do_refill(2, 4);
        run_request(50, 1'b0, 1'b1, 0, 3);
        checks++;
        if (inventory[3:0] !== 4'd11) begin
            errors++;
            $display("[TB] FAIL refill_overlap: got %0d expected 11", inventory[3:0]);
        end
    endtask

    task automatic test_ignored_start();
        run_request(65, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid();
        int  cyc;
        bit  spurious;
        @(negedge clk);
        start  = 1'b1;
        amount = 7'd65;
        @(posedge clk);
        #1;
        start  = 1'b0;
        amount = '0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || counts !== '0 || inventory !== 12'haaa) begin
            errors++;
            $display("[TB] FAIL reset_mid: got ready=%b counts=%h inv=%h expected 1/000/aaa", ready, counts, inventory);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        spurious = 1'b0;
        for (cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (done || fail) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("[TB] FAIL reset_mid_pulse: got done/fail after reset expected none");
        end
    endtask

    task automatic test_back_to_back();
        int amt, ch, qty;
        for (int k = 0; k < 12; k++) begin
            amt = $urandom_range(0, 127);
            ch  = $urandom_range(0, 3);
            qty = $urandom_range(0, 15);
            if ((k % 3) == 0) do_refill(ch, qty);
            run_request(amt, 1'b0, (k % 2) == 1, ch, qty);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        start      = 1'b0;
        amount     = '0;
        refill     = 1'b0;
        refill_ch  = '0;
        refill_qty = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        test_reset();
        test_greedy();
        test_zero();
        test_indivisible();
        test_exhaustion();
        test_refill();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Parametrised change-making engine for the vending datapath. It sits between the credit/price subtractor and the coin-output and display logic. Given a change amount, it iteratively removes coins greedily from N denomination channels, largest first, and respects a per-channel coin inventory. It reports per-channel coin counts on success, or a fail pulse when exact change cannot be made, and it maintains the inventory with refill support.

## Interface
- `W`, 7: amount / remainder width.
- `N`, 3: number of coin channels.
- `CW`, 4: per-channel count / inventory width.
- `DENOM`, {7'd5,7'd10,7'd25}: packed N*W. Channel i value = `DENOM[i*W +: W]`. Channels are strictly descending (ch0 = 25, ch1 = 10, ch2 = 5). All values are nonzero.
- `INIT_INV`, 10: inventory loaded into every channel on reset. Must be ≤ 2^CW-1.

- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low. 0 forces reset immediately.
- `start`, in, 1: request. Sampled only in IDLE.
- `amount`, in, W: change to dispense. Captured with `start`.
- `ready`, out, 1: high in IDLE.
- `done`, out, 1: high exactly one cycle (COMMIT) on success.
- `fail`, out, 1: high exactly one cycle (FAIL) on failure.
- `counts`, out, N*CW: per-channel coins of the last successful request. Channel i is at `[i*CW +: CW]`.
- `refill`, in, 1: add coins to one channel.
- `refill_ch`, in, $clog2(N): target channel. Values ≥ N are ignored.
- `refill_qty`, in, CW: coins added.
- `inventory`, out, N*CW: current stock per channel.

## Operation
- **State machine:** IDLE, CALC, COMMIT, FAIL.
- **Reset values:**
  - State IDLE.
  - `counts` = 0. Working counts = 0. Remainder = 0.
  - Channel index = 0.
  - `inventory` = `INIT_INV` on every channel.
  - `done` = `fail` = 0; `ready` = 1.
- **IDLE:**
  - On `start`: remainder ← `amount`, working counts ← 0, channel index ← 0, go to CALC.
  - `start` in any other state is ignored (no queueing).
- **CALC:** one decision per cycle, evaluated in priority order.
  1. If remainder == 0, go to COMMIT.
  2. Else if remainder ≥ DENOM[ch] and work[ch] < inventory[ch]:
     - remainder -= DENOM[ch] and work[ch]++.
     - If the new remainder == 0, go to COMMIT. Otherwise stay in CALC.
  3. Else if ch < N-1: ch++ and stay in CALC.
  4. Else go to FAIL.
- **COMMIT:**
  - `done` is asserted.
  - `counts` holds the working counts, loaded on the edge entering COMMIT.
  - On the edge leaving COMMIT, `inventory[i]` -= `work[i]` for every channel. Go to IDLE.
- **FAIL:**
  - `fail` is asserted. Go to IDLE.
  - `counts` and `inventory` are unchanged; nothing is dispensed.
- **Greedy rule:** greedy only, no backtracking. An amount that is solvable only non-greedily under limited stock fails. This is accepted behaviour.
- **Arithmetic:**
  - The remainder is unsigned W bits and is only subtracted when ≥ denomination, so it never underflows.
  - work[i] ≤ inventory[i] ≤ 2^CW-1, so work counters never overflow.
- **Refill:**
  - Accepted in any state.
  - `inventory[refill_ch]` ← min(inv + qty, 2^CW-1), saturating.
  - Coincident with the COMMIT decrement on the same channel: the result is sat(inv - work + qty).
  - A refill during CALC becomes visible to the availability check on the next cycle.
- **Reset mid-operation:** the request is abandoned. No `done`/`fail` is produced and inventory returns to `INIT_INV`.

## Timing
- `start` is sampled at edge k. CALC begins at k+1.
- Each coin taken or each channel advance costs one CALC cycle.
- `done`/`fail` rise one cycle after the final CALC decision and last one cycle. `ready` returns the following cycle.
- Worst-case latency is 1 + (total coins) + (N-1) + 1 cycles.
- `counts` is stable from the `done` cycle until the next COMMIT.
- `inventory` reflects the dispense from the cycle after `done`.

## Test plan
1. **Greedy success.** Reset, then `amount`=65.
   - 6 CALC cycles (take, take, advance, take, advance, take).
   - `done` is high 7 cycles after the start edge.
   - `counts` = {1,1,2} (ch2..ch0).
   - `inventory` = {9,9,8}.
2. **Zero amount.** `amount`=0.
   - `done` is high 2 cycles after start.
   - `counts` = 0 and inventory is unchanged.
3. **Indivisible amount.** `amount`=63.
   - Path: 25, 25, advance, 10, advance, ch2 cannot take.
   - `fail` pulses. `counts` keeps its previous value and inventory is unchanged.
4. **Inventory exhaustion.**
   - Dispense 50 five times, leaving ch0 = 0.
   - Then dispense 50: `counts` = {0,5,0}, `inventory` ch1 = 5.
   - Then dispense 75: ch1 supplies 5 coins (50), ch2 supplies 5 coins (25); `done`, `counts` = {5,5,0}.
5. **Refill saturation and overlap.**
   - Refill ch2 with qty 15 from inventory 10: result 15.
   - Refill ch0 qty 3 in the COMMIT cycle of a 50 request (work ch0 = 2, inventory 10): result 11.
6. **Ignored start and reset mid-operation.**
   - Pulse `start` during CALC: no effect.
   - Drive `reset` low during CALC of 65: `ready` = 1, `counts` = 0, `inventory` = 10 each, and no `done` is produced.
